// File: rtl/guess_pkg.sv
// Shared encodings for the number-guessing game controller: FSM states,
// key codes, result codes and the LFSR-to-secret mapping.
package guess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY1 = 3'd1,
    ST_ENTRY2 = 3'd2,
    ST_RESULT = 3'd3,
    ST_WIN    = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ENTER   = 4'd10;
  localparam logic [3:0] KEY_CLEAR   = 4'd11;
  localparam logic [3:0] KEY_NEWGAME = 4'd12;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LOW   = 2'b01;
  localparam logic [1:0] RES_HIGH  = 2'b10;
  localparam logic [1:0] RES_EQUAL = 2'b11;

  // Fold the low seven LFSR bits into 0..99.
  function automatic logic [6:0] secret_of(input logic [6:0] v);
    return (v < 7'd100) ? v : v - 7'd100;
  endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr8.sv
// Free-running 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1),
// loaded with a non-zero seed while reset is high.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= seed;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// Two-digit BCD number-guessing game controller driven by debounced one-hot keys.
// Optional entry timeout is compiled in with macro GUESS_TIMEOUT_EN.
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 250_000_000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_deb,
  output logic [7:0]  guess_bcd,
  output logic [1:0]  digit_cnt,
  output logic [7:0]  tries,
  output logic [1:0]  result,
  output logic        win,
  output logic [6:0]  secret
);

  state_t      state_q, state_d;
  logic [15:0] key_prev;
  logic [3:0]  key_code;
  logic        press_ev;
  logic        key_onehot;
  logic        tmo_hit;
  logic [7:0]  lfsr_q;
  logic [7:0]  guess_d, tries_d;
  logic [1:0]  cnt_d, result_d;
  logic [6:0]  secret_d;
  logic [6:0]  guess_val;
  logic        in_entry;

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] t);
    if (t == 8'h99)        return t;
    else if (t[3:0] == 4'd9) return {t[7:4] + 4'd1, 4'd0};
    else                   return {t[7:4], t[3:0] + 4'd1};
  endfunction

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign key_onehot = (key_deb != 16'd0) && ((key_deb & (key_deb - 16'd1)) == 16'd0);
  assign press_ev   = key_onehot && (key_prev == 16'd0);
  assign in_entry   = (state_q == ST_ENTRY1) || (state_q == ST_ENTRY2);
  assign guess_val  = 7'(guess_bcd[7:4]) * 7'd10 + 7'(guess_bcd[3:0]);
  assign win        = (state_q == ST_WIN);

  always_comb begin
    key_code = 4'd0;
    for (int i = 0; i < 16; i++)
      if (key_deb[i]) key_code = 4'(i);
  end

`ifdef GUESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-cycle counter only runs while an entry is partially typed.
  assign tmo_hit = in_entry && !press_ev && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                tmo_cnt <= '0;
    else if (!in_entry || press_ev || tmo_hit) tmo_cnt <= '0;
    else                                    tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_bcd;
    cnt_d    = digit_cnt;
    tries_d  = tries;
    result_d = result;
    secret_d = secret;

    if (tmo_hit) begin
      guess_d = 8'h00;
      cnt_d   = 2'd0;
      state_d = ST_IDLE;
    end else if (press_ev) begin
      if (key_code == KEY_NEWGAME) begin
        secret_d = secret_of(lfsr_q[6:0]);
        tries_d  = 8'h00;
        result_d = RES_NONE;
        guess_d  = 8'h00;
        cnt_d    = 2'd0;
        state_d  = ST_IDLE;
      end else if (state_q != ST_WIN) begin
        if (key_code == KEY_CLEAR) begin
          guess_d = 8'h00;
          cnt_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (key_code < 4'd10) begin
          if (state_q == ST_IDLE || state_q == ST_RESULT) begin
            guess_d = {4'd0, key_code};
            cnt_d   = 2'd1;
            state_d = ST_ENTRY1;
          end else if (state_q == ST_ENTRY1) begin
            guess_d = {guess_bcd[3:0], key_code};
            cnt_d   = 2'd2;
            state_d = ST_ENTRY2;
          end
        end else if (key_code == KEY_ENTER && in_entry) begin
          tries_d = bcd_inc_sat(tries);
          if (guess_val == secret) begin
            result_d = RES_EQUAL;
            state_d  = ST_WIN;
          end else begin
            result_d = (guess_val < secret) ? RES_LOW : RES_HIGH;
            state_d  = ST_RESULT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_prev  <= 16'd0;
      guess_bcd <= 8'h00;
      digit_cnt <= 2'd0;
      tries     <= 8'h00;
      result    <= RES_NONE;
      secret    <= secret_of(LFSR_SEED[6:0]);
    end else begin
      state_q   <= state_d;
      key_prev  <= key_deb;
      guess_bcd <= guess_d;
      digit_cnt <= cnt_d;
      tries     <= tries_d;
      result    <= result_d;
      secret    <= secret_d;
    end
  end

endmodule
